// File: rtl/enc_pkg.sv
// enc_pkg: shared direction and Gray-phase constants for the encoder front end
package enc_pkg;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;
    function automatic logic [1:0] ph_up(input logic [1:0] p);
        return p == PH_00 ? PH_01 : p == PH_01 ? PH_11 : p == PH_11 ? PH_10 : PH_00;
    endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus debounce filter for one encoder phase
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic stable;
    logic raw;
    logic hit;
    assign raw = sync[1];
    assign hit = (raw != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    // dout is the value stable takes at the coming edge, so the decoder can act on that same edge
    assign dout = hit ? raw : stable;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync   <= {sync[0], din};
            cnt    <= (raw == stable || hit) ? '0 : cnt + 1'b1;
            stable <= dout;
        end
    end
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: x4 quadrature decoder producing inc/uphdl strobes for the counter
module quad_step_decoder import enc_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic       inc,
    output logic       uphdl,
    output logic       err,
    output logic [1:0] ab_stable
);
    logic da, db;
    logic [1:0] nxt, chg;
    logic stp;
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (.clk(clk), .reset(reset), .din(enc_a), .dout(da));
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (.clk(clk), .reset(reset), .din(enc_b), .dout(db));
    always_comb begin
        nxt = {da, db};
        chg = ab_stable ^ nxt;
        stp = ^chg;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ab_stable <= PH_00;
            inc       <= 1'b0;
            err       <= 1'b0;
            uphdl     <= 1'b0;
        end else begin
            ab_stable <= nxt;
            inc       <= stp;
            err       <= &chg;
            if (stp) uphdl <= (nxt == ph_up(ab_stable)) ? DIR_UP : DIR_DOWN;
        end
    end
endmodule
